// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode hex display driver with frame-aligned shadow loads.
// Define SEVEN_SEG_SCANNER_LZB_EN to enable leading-zero blanking.
module seven_seg_scanner #(
  parameter int DIGITS = 4,
  parameter int DIGIT_PERIOD = 50_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                clk,
  input  logic                sync_nreset,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load_req,
  output logic                load_ack,
  output logic                frame_start,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n
);
  localparam int CW = DIGIT_PERIOD > 1 ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [111:0] SEG_LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d, an_n_q, an_n_d;
  logic [6:0] seg_n_q, seg_n_d;
  logic dp_n_q, dp_n_d, load_ack_q, load_ack_d, frame_start_q, frame_start_d;
  logic slot_end, frame_edge, blank_digit;
  logic [3:0] nib;
`ifdef SEVEN_SEG_SCANNER_LZB_EN
  logic lz;
`endif

  // Outputs are computed from next-state values so the registered pins line up with the state.
  always_comb begin
    slot_end = cnt_q == CW'(DIGIT_PERIOD - 1);
    frame_edge = enable && (state_q == IDLE || (slot_end && idx_q == IW'(DIGITS - 1)));
    load_ack_d = !load_ack_q && load_req && (frame_edge || state_q == IDLE);
    cnt_d = (!enable || state_q == IDLE || slot_end) ? '0 : cnt_q + 1'b1;
    idx_d = (!enable || state_q == IDLE) ? '0 :
            slot_end ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    state_d = !enable ? IDLE : (cnt_d >= CW'(BLANK_CYCLES) ? SHOW : BLANK);
    shadow_d = load_ack_d ? digits_in : shadow_q;
    shadow_dp_d = load_ack_d ? dp_in : shadow_dp_q;
    nib = shadow_d[4*idx_d +: 4];
    blank_digit = 1'b0;
`ifdef SEVEN_SEG_SCANNER_LZB_EN
    lz = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz = lz && shadow_d[4*i +: 4] == 4'h0;
      if (lz && idx_d == IW'(i)) blank_digit = 1'b1;
    end
`endif
    an_n_d = state_d == SHOW ? ~(DIGITS'(1) << idx_d) : '1;
    seg_n_d = (state_d != SHOW || blank_digit) ? 7'h7F : SEG_LUT[7*nib +: 7];
    dp_n_d = !(state_d == SHOW && shadow_dp_d[idx_d]);
    frame_start_d = frame_edge;
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      shadow_dp_q <= '0;
      an_n_q <= '1;
      seg_n_q <= 7'h7F;
      dp_n_q <= 1'b1;
      load_ack_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      an_n_q <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q <= dp_n_d;
      load_ack_q <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n = an_n_q;
  assign seg_n = seg_n_q;
  assign dp_n = dp_n_q;
  assign load_ack = load_ack_q;
  assign frame_start = frame_start_q;
endmodule
